// File: rtl/alu_bk_pipe.sv
// Two-stage WIDTH-bit ALU (XOR/AND/ADD/SUB/OR/ADC/SBB/NOT A) built on a Brent-Kung
// prefix adder, with valid/ready handshakes and a carry flag for multi-word chains.
module alu_bk_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf
);
    localparam int L = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_XOR = 3'b000, OP_AND = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
        OP_OR  = 3'b100, OP_ADC = 3'b101, OP_SBB = 3'b110, OP_NOTA = 3'b111
    } op_e;

    logic             s1_valid_q, s2_valid_q, s1_load, s2_load;
    logic [WIDTH-1:0] a_q, b_q;
    logic             cin_q;
    op_e              op_q;
    logic             cf_q;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, z_q, n_q, v_q, c_d, z_d, n_d, v_d;

    assign s2_load   = !s2_valid_q || out_ready;
    assign s1_load   = !s1_valid_q || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;
    assign result    = res_q;
    assign out_carry = c_q;
    assign out_zero  = z_q;
    assign out_neg   = n_q;
    assign out_ovf   = v_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            op_q       <= OP_XOR;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                a_q   <= a;
                b_q   <= b;
                cin_q <= cin;
                op_q  <= op_e'(op);
            end
        end
    end

    // Operand conditioning: subtracting ops invert B; carry-in depends on op.
    logic             arith, inv_b, c0;
    logic [WIDTH-1:0] bx, p, g;
    always_comb begin
        arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_ADC) || (op_q == OP_SBB);
        inv_b = (op_q == OP_SUB) || (op_q == OP_SBB);
        bx    = inv_b ? ~b_q : b_q;
        p     = a_q ^ bx;
        g     = a_q & bx;
        case (op_q)
            OP_ADD:  c0 = cin_q;
            OP_SUB:  c0 = 1'b1;
            default: c0 = cf_q;
        endcase
    end

    // Brent-Kung tree over group (G,P) anchored at bit 0; carry-in merged at the end.
    logic [L:0][WIDTH-1:0]   gu, pu;
    logic [L-1:0][WIDTH-1:0] gd, pd;
    assign gu[0] = g;
    assign pu[0] = p;
    assign gd[0] = gu[L];
    assign pd[0] = pu[L];

    for (genvar k = 1; k <= L; k++) begin : g_up
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i + 1) % (1 << k) == 0) begin : g_node
                assign gu[k][i] = gu[k-1][i] | (pu[k-1][i] & gu[k-1][i-(1<<(k-1))]);
                assign pu[k][i] = pu[k-1][i] & pu[k-1][i-(1<<(k-1))];
            end else begin : g_pass
                assign gu[k][i] = gu[k-1][i];
                assign pu[k][i] = pu[k-1][i];
            end
        end
    end

    for (genvar j = 1; j < L; j++) begin : g_dn
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i >= (1 << (L-j))) && ((i + 1) % (1 << (L-j)) == (1 << (L-j-1)))) begin : g_node
                assign gd[j][i] = gd[j-1][i] | (pd[j-1][i] & gd[j-1][i-(1<<(L-j-1))]);
                assign pd[j][i] = pd[j-1][i] & pd[j-1][i-(1<<(L-j-1))];
            end else begin : g_pass
                assign gd[j][i] = gd[j-1][i];
                assign pd[j][i] = pd[j-1][i];
            end
        end
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    assign carry[0]       = c0;
    assign carry[WIDTH:1] = gd[L-1] | (pd[L-1] & {WIDTH{c0}});
    assign sum            = p ^ carry[WIDTH-1:0];

    always_comb begin
        case (op_q)
            OP_XOR:  res_d = a_q ^ b_q;
            OP_AND:  res_d = a_q & b_q;
            OP_OR:   res_d = a_q | b_q;
            OP_NOTA: res_d = ~a_q;
            default: res_d = sum;
        endcase
        c_d = arith & carry[WIDTH];
        v_d = arith & (a_q[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != a_q[WIDTH-1]);
        z_d = (res_d == '0);
        n_d = res_d[WIDTH-1];
    end

    // CF updates as S2 loads, so a following ADC/SBB in S1 always sees it in time.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            cf_q       <= 1'b0;
            res_q      <= '0;
            c_q        <= 1'b0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            v_q        <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_q <= res_d;
                c_q   <= c_d;
                z_q   <= z_d;
                n_q   <= n_d;
                v_q   <= v_d;
                if (arith) cf_q <= carry[WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_alu_bk_pipe.sv
// Directed bench for alu_bk_pipe (WIDTH=8): ops, flags, CF chaining, backpressure, reset.
module tb_alu_bk_pipe;
    localparam int W = 8;
    localparam logic [2:0] XOR_ = 3'd0, AND_ = 3'd1, ADD_ = 3'd2, SUB_ = 3'd3,
                           OR_  = 3'd4, ADC_ = 3'd5, SBB_ = 3'd6, NOTA = 3'd7;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, out_valid, out_ready;
    logic         out_carry, out_zero, out_neg, out_ovf;
    logic [W-1:0] a, b, result;
    logic [2:0]   op;
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    alu_bk_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .out_carry(out_carry), .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf)
    );

    logic [2:0]   sq_op  [8];
    logic [W-1:0] sq_a   [8];
    logic [W-1:0] sq_b   [8];
    logic         sq_cin [8];
    int           sq_n;
    logic [W-1:0] col_res[8];
    logic [3:0]   col_flg[8];
    int           col_cyc[8];
    int           col_n;
    logic         rdy_log[16];
    logic         vld_log[16];
    logic [W-1:0] res_log[16];

    task automatic set_beat(input int i, input logic [2:0] o, input logic [W-1:0] x,
                            input logic [W-1:0] y, input logic c);
        sq_op[i] = o; sq_a[i] = x; sq_b[i] = y; sq_cin[i] = c;
    endtask

    // Issue sq_* beats as fast as in_ready allows; out_ready held low for 'stall' cycles.
    task automatic stream(input int stall);
        int k;
        k = 0;
        col_n = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= stall);
            in_valid  = (k < sq_n);
            if (k < sq_n) begin
                op = sq_op[k]; a = sq_a[k]; b = sq_b[k]; cin = sq_cin[k];
            end
            #1;
            rdy_log[cyc] = in_ready;
            vld_log[cyc] = out_valid;
            res_log[cyc] = result;
            if (out_valid && out_ready && col_n < 8) begin
                col_res[col_n] = result;
                col_flg[col_n] = {out_carry, out_zero, out_neg, out_ovf};
                col_cyc[col_n] = cyc;
                col_n++;
            end
            if (in_valid && in_ready) k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; op = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({out_valid, result, out_carry, out_zero, out_neg, out_ovf} !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs got v=%b r=%h f=%b%b%b%b want all 0",
                     out_valid, result, out_carry, out_zero, out_neg, out_ovf);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_logic;
        logic [11:0] exp [4];
        exp = '{12'h660, 12'h882, 12'hEE2, 12'h550};
        set_beat(0, XOR_, 8'hAA, 8'hCC, 1'b0);
        set_beat(1, AND_, 8'hAA, 8'hCC, 1'b1);
        set_beat(2, OR_,  8'hAA, 8'hCC, 1'b0);
        set_beat(3, NOTA, 8'hAA, 8'hCC, 1'b0);
        sq_n = 4;
        stream(0);
        tests++;
        if (col_n !== 4) begin fails++; $display("FAIL logic_count got %0d want 4", col_n); end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({col_res[i], col_flg[i]} !== exp[i]) begin
                fails++;
                $display("FAIL logic[%0d] got %h/%b want %h/%b", i, col_res[i], col_flg[i],
                         exp[i][11:4], exp[i][3:0]);
            end
        end
        tests++;
        if (col_cyc[0] !== 2) begin
            fails++; $display("FAIL latency got cycle %0d want 2", col_cyc[0]);
        end
    endtask

    task automatic test_add_sub;
        logic [11:0] exp [5];
        exp = '{12'h803, 12'h00C, 12'h068, 12'hFF2, 12'h7F9};
        set_beat(0, ADD_, 8'h7F, 8'h01, 1'b0);
        set_beat(1, ADD_, 8'hFF, 8'h00, 1'b1);
        set_beat(2, SUB_, 8'h07, 8'h01, 1'b0);
        set_beat(3, SUB_, 8'h01, 8'h02, 1'b0);
        set_beat(4, SUB_, 8'h80, 8'h01, 1'b0);
        sq_n = 5;
        stream(0);
        tests++;
        if (col_n !== 5) begin fails++; $display("FAIL addsub_count got %0d want 5", col_n); end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({col_res[i], col_flg[i]} !== exp[i]) begin
                fails++;
                $display("FAIL addsub[%0d] got %h/%b want %h/%b", i, col_res[i], col_flg[i],
                         exp[i][11:4], exp[i][3:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] exp [5];
        exp = '{12'h00C, 12'h010, 12'h004, 12'hFF2, 12'hFF2};
        set_beat(0, ADD_, 8'hFF, 8'h01, 1'b0);
        set_beat(1, ADC_, 8'h00, 8'h00, 1'b0);
        set_beat(2, ADC_, 8'h00, 8'h00, 1'b0);
        set_beat(3, SUB_, 8'h00, 8'h01, 1'b0);
        set_beat(4, SBB_, 8'h00, 8'h00, 1'b0);
        sq_n = 5;
        stream(0);
        tests++;
        if (col_n !== 5) begin fails++; $display("FAIL b2b_count got %0d want 5", col_n); end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({col_res[i], col_flg[i]} !== exp[i] || col_cyc[i] !== i + 2) begin
                fails++;
                $display("FAIL b2b[%0d] got %h/%b @%0d want %h/%b @%0d", i, col_res[i],
                         col_flg[i], col_cyc[i], exp[i][11:4], exp[i][3:0], i + 2);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [11:0] exp [3];
        exp = '{12'h020, 12'h040, 12'h060};
        set_beat(0, ADD_, 8'h01, 8'h01, 1'b0);
        set_beat(1, ADD_, 8'h02, 8'h02, 1'b0);
        set_beat(2, ADD_, 8'h03, 8'h03, 1'b0);
        sq_n = 3;
        stream(4);
        tests++;
        if ({rdy_log[0], rdy_log[1], rdy_log[2], rdy_log[3]} !== 4'b1100) begin
            fails++;
            $display("FAIL bp_in_ready got %b%b%b%b want 1100", rdy_log[0], rdy_log[1],
                     rdy_log[2], rdy_log[3]);
        end
        for (int c = 2; c < 4; c++) begin
            tests++;
            if ({vld_log[c], res_log[c]} !== {1'b1, 8'h02}) begin
                fails++;
                $display("FAIL bp_hold[%0d] got v=%b r=%h want v=1 r=02", c, vld_log[c], res_log[c]);
            end
        end
        tests++;
        if (col_n !== 3) begin fails++; $display("FAIL bp_count got %0d want 3", col_n); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({col_res[i], col_flg[i]} !== exp[i] || col_cyc[i] !== i + 4) begin
                fails++;
                $display("FAIL bp_out[%0d] got %h/%b @%0d want %h/%b @%0d", i, col_res[i],
                         col_flg[i], col_cyc[i], exp[i][11:4], exp[i][3:0], i + 4);
            end
        end
    endtask

    task automatic test_reset_mid;
        int stray;
        set_beat(0, ADD_, 8'hFF, 8'h01, 1'b0);
        sq_n = 1;
        stream(0);
        tests++;
        if (col_n !== 1 || {col_res[0], col_flg[0]} !== 12'h00C) begin
            fails++; $display("FAIL cf_set got n=%0d %h/%b want 1 00/1100", col_n, col_res[0], col_flg[0]);
        end
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; op = ADD_; a = 8'hFF; b = 8'h01; cin = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests++;
        if ({out_valid, in_ready} !== 2'b10) begin
            fails++; $display("FAIL mid_full got v=%b rdy=%b want 1 0", out_valid, in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({out_valid, result, out_carry, out_zero, out_neg, out_ovf} !== 13'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset got v=%b r=%h f=%b%b%b%b rdy=%b want 0 00 0000 1", out_valid,
                     result, out_carry, out_zero, out_neg, out_ovf, in_ready);
        end
        out_ready = 1'b1;
        stray = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) stray++;
        end
        tests++;
        if (stray !== 0) begin fails++; $display("FAIL mid_discard got %0d beats want 0", stray); end
        set_beat(0, ADC_, 8'h10, 8'h20, 1'b0);
        sq_n = 1;
        stream(0);
        tests++;
        if (col_n !== 1 || {col_res[0], col_flg[0]} !== 12'h300) begin
            fails++; $display("FAIL cf_cleared got n=%0d %h/%b want 1 30/0000", col_n, col_res[0], col_flg[0]);
        end
    endtask

    initial begin
        test_reset();
        test_logic();
        test_add_sub();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
